// File: rtl/pipe_ctrl_hazard_unit.sv
// Pipeline control and hazard unit for the pipelined MIPS core.
// Carries the decoded ID-stage control bundle through the ID/EX, EX/MEM and
// MEM/WB control registers. Generates the PC/IF-ID stall, the IF-ID flush and
// the EX operand forwarding selects. Also sequences a multi-cycle EX operation
// whose busy window freezes the front of the pipe.
module pipe_ctrl_hazard_unit #(
    parameter int REG_AW = 5,   // register-address width; r0 is hard-wired zero
    parameter int MC_LAT = 4    // EX occupancy of a multi-cycle op, 1..15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // decoded controls of the instruction currently in ID
    input  logic              i_ID_RegWr,
    input  logic              i_ID_MemRead,
    input  logic              i_ID_MemWrite,
    input  logic [1:0]        i_ID_MemtoReg,
    input  logic [REG_AW-1:0] i_ID_Dst,
    input  logic [REG_AW-1:0] i_ID_Rs,
    input  logic [REG_AW-1:0] i_ID_Rt,
    input  logic              i_ID_UsesRs,
    input  logic              i_ID_UsesRt,
    input  logic              i_ID_Jump,
    input  logic              i_ID_MultiCycle,
    // branch resolution from EX
    input  logic              i_EX_BranchTaken,
    // front-end controls
    output logic              o_PC_Stall,
    output logic              o_IFID_Stall,
    output logic              o_IFID_Flush,
    // ID/EX control register
    output logic              o_EX_RegWr,
    output logic              o_EX_MemRead,
    output logic              o_EX_MemWrite,
    output logic              o_EX_MultiCycle,
    output logic [1:0]        o_EX_MemtoReg,
    output logic [REG_AW-1:0] o_EX_Dst,
    // EX/MEM control register
    output logic              o_MEM_RegWr,
    output logic              o_MEM_MemRead,
    output logic              o_MEM_MemWrite,
    output logic [1:0]        o_MEM_MemtoReg,
    output logic [REG_AW-1:0] o_MEM_Dst,
    // MEM/WB control register
    output logic              o_WB_RegWr,
    output logic [1:0]        o_WB_MemtoReg,
    output logic [REG_AW-1:0] o_WB_Dst,
    // forwarding selects: 00 register file, 01 WB, 10 MEM
    output logic [1:0]        o_FwdA,
    output logic [1:0]        o_FwdB,
    output logic              o_MC_Busy
);

    // Counter is wide enough for the largest legal latency (15).
    localparam int CNT_W = 4;
    // Value loaded on entry: the op then leaves EX after MC_LAT cycles,
    // of which MC_LAT-1 are busy (frozen) cycles.
    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT - 1);

    typedef struct packed {
        logic              regWr;
        logic              memRead;
        logic              memWrite;
        logic              multiCycle;
        logic [1:0]        memtoReg;
        logic [REG_AW-1:0] dst;
    } exCtrl_t;

    typedef struct packed {
        logic              regWr;
        logic              memRead;
        logic              memWrite;
        logic [1:0]        memtoReg;
        logic [REG_AW-1:0] dst;
    } memCtrl_t;

    typedef struct packed {
        logic              regWr;
        logic [1:0]        memtoReg;
        logic [REG_AW-1:0] dst;
    } wbCtrl_t;

    genvar gi;

    exCtrl_t           idCtrl;
    exCtrl_t           exCtrlReg, exCtrlNext;
    logic [REG_AW-1:0] exRsReg, exRsNext;
    logic [REG_AW-1:0] exRtReg, exRtNext;
    memCtrl_t          memCtrlReg, memCtrlNext;
    wbCtrl_t           wbCtrlReg, wbCtrlNext;
    logic [CNT_W-1:0]  mcCntReg, mcCntNext;

    logic              mcBusy;
    logic              loadUse;
    logic              pcStall, ifidStall, ifidFlush;
    logic              idexHold, idexBubble, exmemBubble;

    // Source-operand views used by the per-operand generate loops.
    // Index 0 is Rs (operand A), index 1 is Rt (operand B).
    logic [2*REG_AW-1:0] idSrc;
    logic [1:0]          idUses;
    logic [1:0]          srcHit;
    logic [2*REG_AW-1:0] exSrc;
    logic [1:0]          memHit;
    logic [1:0]          wbHit;
    logic [3:0]          fwdSel;

    // Pack the decoded ID controls into the bundle the ID/EX register stores.
    always_comb begin
        idCtrl            = '0;
        idCtrl.regWr      = i_ID_RegWr;
        idCtrl.memRead    = i_ID_MemRead;
        idCtrl.memWrite   = i_ID_MemWrite;
        idCtrl.multiCycle = i_ID_MultiCycle;
        idCtrl.memtoReg   = i_ID_MemtoReg;
        idCtrl.dst        = i_ID_Dst;
    end

    assign idSrc  = {i_ID_Rt, i_ID_Rs};
    assign idUses = {i_ID_UsesRt, i_ID_UsesRs};
    assign exSrc  = {exRtReg, exRsReg};

    // Per-source load-use match against the load sitting in EX.
    generate
        for (gi = 0; gi < 2; gi++) begin : gLoadUse
            assign srcHit[gi] = idUses[gi] &&
                                (idSrc[gi*REG_AW +: REG_AW] == exCtrlReg.dst);
        end
    endgenerate

    // Busy only while the op in EX is multi-cycle and has cycles left.
    assign mcBusy  = exCtrlReg.multiCycle && (mcCntReg != '0);
    // A load into r0 never produces a hazard.
    assign loadUse = exCtrlReg.memRead && (exCtrlReg.dst != '0) && (|srcHit);

    // Resolve stall/flush/bubble in priority order:
    // reset > MC busy > taken branch > load-use > jump.
    always_comb begin
        pcStall     = 1'b0;
        ifidStall   = 1'b0;
        ifidFlush   = 1'b0;
        idexHold    = 1'b0;
        idexBubble  = 1'b0;
        exmemBubble = 1'b0;
        if (i_rst) begin
            // everything is cleared by the register process
        end else if (mcBusy) begin
            // freeze front of the pipe; branch/jump evaluation is suppressed
            pcStall     = 1'b1;
            ifidStall   = 1'b1;
            idexHold    = 1'b1;
            exmemBubble = 1'b1;
        end else if (i_EX_BranchTaken) begin
            // squash both younger instructions; any load-use stall is moot
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
        end else if (loadUse) begin
            // one-cycle stall; a jump in ID flushes once this clears
            pcStall    = 1'b1;
            ifidStall  = 1'b1;
            idexBubble = 1'b1;
        end else if (i_ID_Jump) begin
            ifidFlush = 1'b1;
        end
    end

    // Next-state for the ID/EX register, the EX source copies and MC counter.
    always_comb begin
        exCtrlNext = idCtrl;
        exRsNext   = i_ID_Rs;
        exRtNext   = i_ID_Rt;
        mcCntNext  = (mcCntReg != '0) ? (mcCntReg - 1'b1) : '0;
        if (idexHold) begin
            exCtrlNext = exCtrlReg;
            exRsNext   = exRsReg;
            exRtNext   = exRtReg;
        end else if (idexBubble) begin
            exCtrlNext = '0;
            exRsNext   = '0;
            exRtNext   = '0;
        end else if (i_ID_MultiCycle) begin
            mcCntNext = MC_LOAD;
        end
    end

    // Next-state for EX/MEM and MEM/WB; EX/MEM takes bubbles while EX is busy.
    always_comb begin
        memCtrlNext          = '0;
        wbCtrlNext           = '0;
        if (!exmemBubble) begin
            memCtrlNext.regWr    = exCtrlReg.regWr;
            memCtrlNext.memRead  = exCtrlReg.memRead;
            memCtrlNext.memWrite = exCtrlReg.memWrite;
            memCtrlNext.memtoReg = exCtrlReg.memtoReg;
            memCtrlNext.dst      = exCtrlReg.dst;
        end
        wbCtrlNext.regWr    = memCtrlReg.regWr;
        wbCtrlNext.memtoReg = memCtrlReg.memtoReg;
        wbCtrlNext.dst      = memCtrlReg.dst;
    end

    // Control pipeline registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            exCtrlReg  <= '0;
            exRsReg    <= '0;
            exRtReg    <= '0;
            memCtrlReg <= '0;
            wbCtrlReg  <= '0;
            mcCntReg   <= '0;
        end else begin
            exCtrlReg  <= exCtrlNext;
            exRsReg    <= exRsNext;
            exRtReg    <= exRtNext;
            memCtrlReg <= memCtrlNext;
            wbCtrlReg  <= wbCtrlNext;
            mcCntReg   <= mcCntNext;
        end
    end

    // Forwarding per EX operand; the younger MEM result wins over WB.
    generate
        for (gi = 0; gi < 2; gi++) begin : gFwd
            assign memHit[gi] = memCtrlReg.regWr && (memCtrlReg.dst != '0) &&
                                (memCtrlReg.dst == exSrc[gi*REG_AW +: REG_AW]);
            assign wbHit[gi]  = wbCtrlReg.regWr && (wbCtrlReg.dst != '0) &&
                                (wbCtrlReg.dst == exSrc[gi*REG_AW +: REG_AW]);
            assign fwdSel[gi*2 +: 2] = i_rst       ? 2'b00 :
                                       memHit[gi]  ? 2'b10 :
                                       wbHit[gi]   ? 2'b01 : 2'b00;
        end
    endgenerate

    assign o_PC_Stall      = pcStall;
    assign o_IFID_Stall    = ifidStall;
    assign o_IFID_Flush    = ifidFlush;
    assign o_MC_Busy       = mcBusy;
    assign o_FwdA          = fwdSel[1:0];
    assign o_FwdB          = fwdSel[3:2];

    assign o_EX_RegWr      = exCtrlReg.regWr;
    assign o_EX_MemRead    = exCtrlReg.memRead;
    assign o_EX_MemWrite   = exCtrlReg.memWrite;
    assign o_EX_MultiCycle = exCtrlReg.multiCycle;
    assign o_EX_MemtoReg   = exCtrlReg.memtoReg;
    assign o_EX_Dst        = exCtrlReg.dst;

    assign o_MEM_RegWr     = memCtrlReg.regWr;
    assign o_MEM_MemRead   = memCtrlReg.memRead;
    assign o_MEM_MemWrite  = memCtrlReg.memWrite;
    assign o_MEM_MemtoReg  = memCtrlReg.memtoReg;
    assign o_MEM_Dst       = memCtrlReg.dst;

    assign o_WB_RegWr      = wbCtrlReg.regWr;
    assign o_WB_MemtoReg   = wbCtrlReg.memtoReg;
    assign o_WB_Dst        = wbCtrlReg.dst;

endmodule

// File: doc/pipe_ctrl_hazard_unit.md
Name: pipe_ctrl_hazard_unit

Overview:
- Sequential successor to the combinational instruction decoder in the pipelined MIPS core.
- Takes the decoded ID-stage control bundle, carries it through the ID/EX, EX/MEM and MEM/WB control registers, and generates all stall, flush and forwarding controls.
- Adds a parametrised multi-cycle EX operation (e.g. mul), with a busy counter that freezes the front of the pipe.
- Sits between the decoder/register file and the datapath pipeline registers.

Parameters:
- REG_AW, 5, register-address width; register 0 is hard-wired zero and is never a hazard source.
- MC_LAT, 4, EX occupancy in cycles of a multi-cycle op; legal range 1..15.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_ID_RegWr, i_ID_MemRead, i_ID_MemWrite  in  1 each  decoded controls of the instruction in ID
- i_ID_MemtoReg  in  2  00 ALU, 01 memory, 10 PC+4
- i_ID_Dst  in  REG_AW  destination register, already resolved by RegDst
- i_ID_Rs, i_ID_Rt  in  REG_AW  source registers
- i_ID_UsesRs, i_ID_UsesRt  in  1  the instruction actually reads that source
- i_ID_Jump  in  1  j/jal/jr/jalr decoded in ID
- i_ID_MultiCycle  in  1  instruction needs MC_LAT EX cycles
- i_EX_BranchTaken  in  1  branch resolved taken in EX
- o_PC_Stall, o_IFID_Stall  out  1  hold PC and IF/ID
- o_IFID_Flush  out  1  zero IF/ID next edge
- o_EX_RegWr, o_EX_MemRead, o_EX_MemWrite, o_EX_MultiCycle  out  1  ID/EX control register
- o_EX_MemtoReg  out  2  ID/EX control register
- o_EX_Dst  out  REG_AW  ID/EX control register
- o_MEM_RegWr, o_MEM_MemRead, o_MEM_MemWrite  out  1  EX/MEM control register
- o_MEM_MemtoReg  out  2  EX/MEM control register
- o_MEM_Dst  out  REG_AW  EX/MEM control register
- o_WB_RegWr  out  1  MEM/WB control register
- o_WB_MemtoReg  out  2  MEM/WB control register
- o_WB_Dst  out  REG_AW  MEM/WB control register
- o_FwdA, o_FwdB  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM
- o_MC_Busy  out  1  multi-cycle op still occupying EX

Behaviour:
- Reset: on the edge with i_rst=1, every control register, the EX Rs/Rt copies and the MC counter are cleared to 0. While i_rst=1, all stall/flush outputs are forced 0 and o_FwdA/B=00.
- Stage outputs are registered (1 cycle per stage). Hazard and forwarding outputs are combinational from the registers and ID inputs.
- Bubble: all control bits and Dst zero.
- MC counter loads MC_LAT-1 on the edge an op with MultiCycle=1 enters ID/EX, and decrements to 0 each cycle.
  - o_MC_Busy = o_EX_MultiCycle && cnt!=0.
  - While busy: PC, IF/ID and ID/EX hold; EX/MEM receives a bubble.
  - MC_LAT=1: never busy.
- Load-use hazard: o_EX_MemRead && o_EX_Dst!=0 && ((UsesRs && Rs==o_EX_Dst) || (UsesRt && Rt==o_EX_Dst)). Response: PC and IF/ID stall, ID/EX gets a bubble. Exactly 1 cycle per hazard.
- Taken branch: o_IFID_Flush=1 and ID/EX gets a bubble, squashing 2 younger instructions.
- Jump in ID: o_IFID_Flush=1 only; no stall.
- Priority, highest first: reset > MC busy > taken branch > load-use > jump.
  - MC busy suppresses branch/flush evaluation; EX holds a non-branch.
  - A taken branch cancels a simultaneous load-use stall (the ID instruction is squashed).
  - Load-use beats a jump: the jump flush is deferred to the cycle the stall clears.
- Forwarding for the EX instruction's registered Rs (same rule for Rt → o_FwdB):
  - 10 if o_MEM_RegWr && o_MEM_Dst!=0 && o_MEM_Dst==EX_Rs
  - else 01 if o_WB_RegWr && o_WB_Dst!=0 && o_WB_Dst==EX_Rs
  - else 00
  - MEM wins when both match.
- Reset mid-MC-op: counter cleared and busy drops in the same cycle; the op is abandoned.

Test Plan:
- Reset held 2 cycles with i_ID_Jump=1 → all outputs 0, o_IFID_Flush=0; after release, the jump gives o_IFID_Flush=1 for 1 cycle.
- lw $8 then add $9,$8,$8 → exactly 1 stall cycle (o_PC_Stall=1), one bubble in EX; when add reaches EX, o_FwdA=o_FwdB=01.
- add $8 then sub $10,$8,$8 (adjacent) → no stall, o_FwdA=o_FwdB=10. A lw to $0 followed by a use of $0 → no stall.
- mul with MC_LAT=4 → o_MC_Busy high 3 cycles, PC held 3 cycles, 3 bubbles into MEM. Repeat with MC_LAT=1 → no busy.
- i_EX_BranchTaken=1 while the ID instruction has a load-use hazard → no stall; flush plus ID/EX bubble; o_EX_RegWr=0 next cycle.
- i_rst asserted on the 2nd busy cycle of a mul → o_MC_Busy=0 the next cycle; all stage controls 0.
